mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Single-port memory arbiter for the pipelined core: shares one unified instruction/data memory port between the IF-stage fetch requester and the MEM-stage load/store requester. Serializes accesses with a request/valid handshake on each side and a request/ready handshake to memory, and drives the stall signals that freeze the pipeline registers while an access is outstanding. It sits between the PC/IF_ID logic, the MEM stage and the memory model.

## Interface
- ADDR_W, 64, byte address width (PC and ALU result width)
- DATA_W, 64, data word width
- INSTR_W, 32, instruction width returned to IF
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  ADDR_W  fetch address (PC)
- if_flush  in  1  branch taken/flush: discard fetch in flight
- if_instr  out  INSTR_W  fetched instruction, valid with if_valid
- if_valid  out  1  one-cycle fetch completion pulse
- d_req  in  1  load/store request (MemRead|MemWrite of MEM stage), held until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address (ALU result)
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid with d_valid
- d_valid  out  1  one-cycle data completion pulse
- stall_if  out  1  freeze PC and IF_ID
- stall_mem  out  1  freeze all pipeline registers
- mem_req  out  1  memory access request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  one-cycle memory completion pulse
- grant  out  2  debug: 00 none, 01 IF, 10 data

## Operation
- FSM states: IDLE, IF_WAIT, D_WAIT, RESP.
- IDLE: only state that samples requests. d_req only -> D_WAIT; if_req only -> IF_WAIT; both -> data wins unless last_grant = data, then IF (tie-break toggle, prevents fetch starvation). Neither -> stay.
- On grant: latch address, we, wdata into registers; mem_* driven only from latched values.
- IF_WAIT/D_WAIT: mem_req = 1 until mem_ready. On mem_ready: register mem_rdata (IF takes [INSTR_W-1:0]), go RESP.
- RESP: exactly one cycle; pulse if_valid or d_valid for the granted side; then IDLE. No grant in RESP (requester drops/changes req only after seeing valid).
- Store: d_rdata = 0, d_valid still pulses.
- if_flush while IF_WAIT or in RESP of a fetch: memory transaction completes normally, if_valid suppressed; flush set sticky until RESP. if_flush has no effect on data accesses.
- mem_ready outside *_WAIT ignored.
- stall_mem = d_req & ~d_valid. stall_if = stall_mem | (if_req & ~if_valid) | (if_flush pending).
- last_grant updated on each grant.

## Timing
- Reset (async, immediate): state IDLE, last_grant = IF, all outputs 0 (mem_req drops in same cycle as rst_n falls); in-flight access abandoned, no valid pulse.
- Min latency: req sampled in IDLE cycle N, mem_req high N+1, mem_ready at N+1 earliest, valid at N+2, IDLE N+3. Peak throughput one access per 3 cycles.
- mem_req/mem_addr/mem_we/mem_wdata registered, stable for whole WAIT state.
- if_valid/d_valid/if_instr/d_rdata registered; rdata holds value until next RESP.
- Simultaneous if_req and d_req with one fetch/one data per cycle: grants alternate IF/data/IF.

## Structure
- Shared package (core_pkg): arb_state_t enum {IDLE, IF_WAIT, D_WAIT, RESP}, grant encodings GNT_NONE/GNT_IF/GNT_D, default widths.
- Single module, no sub-module; tie-break is one flop.

## Test plan
- Fetch only: if_req=1, if_addr=0x40, memory returns 0x00A00093 with mem_ready 2 cycles after mem_req -> mem_addr=0x40, if_valid one pulse, if_instr=0x00A00093, stall_if low after pulse.
- Load vs fetch tie after reset: both requests at same cycle, d_addr=0x100 -> data granted first (last_grant reset IF? data wins), then IF; grant sequence 10,01; d_rdata = memory value at 0x100.
- Store: d_we=1, d_addr=0x108, d_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF, d_valid pulse, d_rdata=0, stall_mem low after pulse.
- Flush in flight: if_flush pulsed in IF_WAIT for 0x44 -> mem transaction completes, no if_valid pulse, next fetch at new PC 0x80 proceeds.
- Reset mid-access: rst_n low during D_WAIT -> mem_req, stall_mem, grant 0 immediately; after release IDLE, no stale d_valid.
- Back-to-back fairness: d_req and if_req held continuously for 12 cycles -> grants alternate, neither starved, each access ≥3 cycles apart.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state encoding, grant codes and default widths for the memory port arbiter.
package mem_port_arbiter_pkg;
    localparam int ADDR_W_DEF  = 64;
    localparam int DATA_W_DEF  = 64;
    localparam int INSTR_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        IF_WAIT,
        D_WAIT,
        RESP
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IF   = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF fetches and MEM-stage loads/stores, with pipeline stall generation.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_if_req,
    input  logic [ADDR_W-1:0]  i_if_addr,
    input  logic               i_if_flush,
    output logic [INSTR_W-1:0] o_if_instr,
    output logic               o_if_valid,
    input  logic               i_d_req,
    input  logic               i_d_we,
    input  logic [ADDR_W-1:0]  i_d_addr,
    input  logic [DATA_W-1:0]  i_d_wdata,
    output logic [DATA_W-1:0]  o_d_rdata,
    output logic               o_d_valid,
    output logic               o_stall_if,
    output logic               o_stall_mem,
    output logic               o_mem_req,
    output logic               o_mem_we,
    output logic [ADDR_W-1:0]  o_mem_addr,
    output logic [DATA_W-1:0]  o_mem_wdata,
    input  logic [DATA_W-1:0]  i_mem_rdata,
    input  logic               i_mem_ready,
    output logic [1:0]         o_grant
);
    arb_state_t         r_state;
    arb_state_t         w_next;
    logic               r_last_d;
    logic [1:0]         r_grant;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_we;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_mem_req;
    logic               r_if_valid;
    logic               r_d_valid;
    logic [INSTR_W-1:0] r_if_instr;
    logic [DATA_W-1:0]  r_d_rdata;
    logic               r_flush;
    logic               w_any_req;
    logic               w_pick_d;
    logic               w_grant;
    logic               w_wait;
    logic               w_done;

    // Data wins a tie unless it won the previous grant, so fetches cannot starve.
    assign w_any_req = i_if_req | i_d_req;
    assign w_pick_d  = i_d_req & (~i_if_req | ~r_last_d);
    assign w_grant   = (r_state == IDLE) & w_any_req;
    assign w_wait    = (r_state == IF_WAIT) | (r_state == D_WAIT);
    assign w_done    = w_wait & i_mem_ready;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = w_any_req ? (w_pick_d ? D_WAIT : IF_WAIT) : IDLE;
            IF_WAIT: w_next = i_mem_ready ? RESP : IF_WAIT;
            D_WAIT:  w_next = i_mem_ready ? RESP : D_WAIT;
            RESP:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_d   <= 1'b0;
            r_grant    <= GNT_NONE;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_mem_req  <= 1'b0;
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_if_instr <= '0;
            r_d_rdata  <= '0;
            r_flush    <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            if (w_grant) begin
                r_last_d  <= w_pick_d;
                r_grant   <= w_pick_d ? GNT_D : GNT_IF;
                r_addr    <= w_pick_d ? i_d_addr : i_if_addr;
                r_we      <= w_pick_d & i_d_we;
                r_wdata   <= w_pick_d ? i_d_wdata : '0;
                r_mem_req <= 1'b1;
            end
            if (w_done) begin
                r_mem_req <= 1'b0;
                r_we      <= 1'b0;
                if (r_state == IF_WAIT) begin
                    r_if_instr <= i_mem_rdata[INSTR_W-1:0];
                    r_if_valid <= ~(r_flush | i_if_flush);
                end else begin
                    r_d_rdata <= r_we ? '0 : i_mem_rdata;
                    r_d_valid <= 1'b1;
                end
            end
            if (r_state == RESP)
                r_grant <= GNT_NONE;
            // A flushed fetch still finishes on the bus; the flag only lives until its response slot.
            r_flush <= (r_state == RESP) ? 1'b0 : r_flush | (i_if_flush & (r_state == IF_WAIT));
        end
    end

    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_we;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_grant     = r_grant;
    assign o_if_instr  = r_if_instr;
    assign o_d_rdata   = r_d_rdata;
    assign o_if_valid  = r_if_valid & ~i_if_flush;
    assign o_d_valid   = r_d_valid;
    // Stalls are gated by rst_n so they drop the moment reset asserts.
    assign o_stall_mem = rst_n & i_d_req & ~o_d_valid;
    assign o_stall_if  = o_stall_mem | (rst_n & i_if_req & ~o_if_valid) | r_flush;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter with a latency-programmable memory responder.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_flush = 1'b0;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [63:0] d_addr = '0;
    logic [63:0] d_wdata = '0;
    logic [63:0] d_rdata;
    logic        d_valid;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;
    logic [1:0]  grant;

    int   checks = 0;
    int   errors = 0;
    int   lat = 1;
    int   cnt = 0;
    logic rdy_q = 1'b0;
    logic extra_rdy = 1'b0;

    typedef struct {
        logic        is_d;
        logic [63:0] data;
        logic [1:0]  gnt;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .i_if_flush  (if_flush),
        .o_if_instr  (if_instr),
        .o_if_valid  (if_valid),
        .i_d_req     (d_req),
        .i_d_we      (d_we),
        .i_d_addr    (d_addr),
        .i_d_wdata   (d_wdata),
        .o_d_rdata   (d_rdata),
        .o_d_valid   (d_valid),
        .o_stall_if  (stall_if),
        .o_stall_mem (stall_mem),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .i_mem_ready (mem_ready),
        .o_grant     (grant)
    );

    function automatic logic [63:0] mem_val(input logic [63:0] a);
        return (a == 64'h40)  ? 64'hFFFF_0000_00A0_0093 :
               (a == 64'h100) ? 64'h1122_3344_5566_7788 :
               {a[31:0] ^ 32'hCAFE_0000, ~a[31:0]};
    endfunction

    assign mem_rdata = mem_val(mem_addr);
    assign mem_ready = extra_rdy | ((lat == 0) ? mem_req : rdy_q);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
            cnt   <= 0;
        end else if (rdy_q) begin
            rdy_q <= 1'b0;
            cnt   <= 0;
        end else if (mem_req) begin
            rdy_q <= (cnt + 1 >= lat);
            cnt   <= (cnt + 1 >= lat) ? 0 : cnt + 1;
        end else begin
            cnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_mreq(input string tag);
        int n;
        n = 0;
        while (!mem_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_mem_req_seen"}, {63'b0, mem_req}, 64'd1);
    endtask

    task automatic wait_resp(input string tag, output int cyc);
        logic got;
        exp_t e;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            got = if_valid | d_valid;
        end
        chk({tag, "_valid_seen"}, {63'b0, got}, 64'd1);
        if (got) begin
            if (sb.size() == 0) begin
                chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
            end else begin
                e = sb.pop_front();
                chk({tag, "_side"}, {63'b0, d_valid}, {63'b0, e.is_d});
                chk({tag, "_data"}, d_valid ? d_rdata : {32'b0, if_instr},
                    e.is_d ? e.data : {32'b0, e.data[31:0]});
                chk({tag, "_grant"}, {62'b0, grant}, {62'b0, e.gnt});
            end
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int nv;
        @(negedge clk);
        @(negedge clk);
        chk("rst_grant", {62'b0, grant}, 64'd0);
        chk("rst_mem_req", {63'b0, mem_req}, 64'd0);
        chk("rst_if_valid", {63'b0, if_valid}, 64'd0);
        chk("rst_d_valid", {63'b0, d_valid}, 64'd0);
        chk("rst_stall_if", {63'b0, stall_if}, 64'd0);
        chk("rst_stall_mem", {63'b0, stall_mem}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // fetch only, memory answers two cycles after mem_req
        lat = 2;
        if_req = 1'b1;
        if_addr = 64'h40;
        sb.push_back('{1'b0, 64'h0000_0000_00A0_0093, 2'b01});
        wait_mreq("fetch");
        chk("fetch_mem_addr", mem_addr, 64'h40);
        chk("fetch_mem_we", {63'b0, mem_we}, 64'd0);
        chk("fetch_grant_wait", {62'b0, grant}, 64'd1);
        chk("fetch_stall_if_busy", {63'b0, stall_if}, 64'd1);
        wait_resp("fetch", cyc);
        if_req = 1'b0;
        @(negedge clk);
        chk("fetch_pulse_one_cycle", {63'b0, if_valid}, 64'd0);
        chk("fetch_stall_if_after", {63'b0, stall_if}, 64'd0);
        chk("fetch_instr_hold", {32'b0, if_instr}, 64'h00A0_0093);

        // tie after reset: data first, then fetch
        reset_pulse();
        lat = 1;
        if_req = 1'b1;
        if_addr = 64'h44;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 64'h100;
        sb.push_back('{1'b1, 64'h1122_3344_5566_7788, 2'b10});
        sb.push_back('{1'b0, mem_val(64'h44), 2'b01});
        wait_resp("tie_d", cyc);
        d_req = 1'b0;
        wait_resp("tie_if", cyc);
        if_req = 1'b0;
        @(negedge clk);

        // store
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 64'h108;
        d_wdata = 64'hDEAD_BEEF;
        sb.push_back('{1'b1, 64'h0, 2'b10});
        wait_mreq("store");
        chk("store_mem_we", {63'b0, mem_we}, 64'd1);
        chk("store_mem_wdata", mem_wdata, 64'hDEAD_BEEF);
        chk("store_mem_addr", mem_addr, 64'h108);
        chk("store_stall_mem_busy", {63'b0, stall_mem}, 64'd1);
        wait_resp("store", cyc);
        d_req = 1'b0;
        d_we = 1'b0;
        @(negedge clk);
        chk("store_stall_mem_after", {63'b0, stall_mem}, 64'd0);
        chk("store_d_valid_low", {63'b0, d_valid}, 64'd0);

        // flush in flight, then refetch at the new PC
        lat = 3;
        if_req = 1'b1;
        if_addr = 64'h44;
        wait_mreq("flush");
        chk("flush_mem_addr", mem_addr, 64'h44);
        if_flush = 1'b1;
        if_addr = 64'h80;
        @(negedge clk);
        if_flush = 1'b0;
        chk("flush_stall_if_pending", {63'b0, stall_if}, 64'd1);
        nv = 0;
        for (int i = 0; i < 30 && !(mem_req && mem_addr == 64'h80); i++) begin
            @(negedge clk);
            nv += int'(if_valid);
        end
        chk("flush_no_valid", 64'(nv), 64'd0);
        chk("flush_refetch_addr", mem_addr, 64'h80);
        sb.push_back('{1'b0, mem_val(64'h80), 2'b01});
        wait_resp("refetch", cyc);
        if_req = 1'b0;
        @(negedge clk);

        // reset in the middle of a load
        lat = 5;
        d_req = 1'b1;
        d_addr = 64'h200;
        wait_mreq("rstmid");
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_mem_req", {63'b0, mem_req}, 64'd0);
        chk("rstmid_stall_mem", {63'b0, stall_mem}, 64'd0);
        chk("rstmid_grant", {62'b0, grant}, 64'd0);
        d_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            extra_rdy = (i == 1);
            @(negedge clk);
            nv += int'(if_valid | d_valid | mem_req);
        end
        extra_rdy = 1'b0;
        chk("rstmid_quiet", 64'(nv), 64'd0);
        chk("rstmid_idle_grant", {62'b0, grant}, 64'd0);

        // both requesters held: grants alternate at peak throughput
        lat = 0;
        d_addr = 64'h308;
        if_addr = 64'h300;
        for (int i = 0; i < 6; i++)
            sb.push_back((i % 2 == 0) ? '{1'b1, mem_val(64'h308), 2'b10} : '{1'b0, mem_val(64'h300), 2'b01});
        d_req = 1'b1;
        if_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_resp("fair", cyc);
            if (i == 0)
                chk("fair_min_latency", 64'(cyc), 64'd2);
            else
                chk("fair_gap_ge3", {63'b0, cyc >= 3}, 64'd1);
        end
        d_req = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
